// File: rtl/ppt_pkg.sv
// Shared types and constants for the PPT firing controller.
package ppt_pkg;

  localparam int FW = 16;
  localparam logic [FW-1:0] MIN_PERIOD = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } ppt_state_e;

  function automatic logic [FW-1:0] eff_period(input logic [FW-1:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  // Pulse width is clamped so every period keeps at least one low tick.
  function automatic logic [FW-1:0] eff_width(input logic [FW-1:0] p, input logic [FW-1:0] w);
    logic [FW-1:0] pm1;
    pm1 = eff_period(p) - FW'(1);
    return (w < pm1) ? w : pm1;
  endfunction

endpackage

// File: rtl/ppt_prescaler.sv
// Free-running 32-bit prescaler: one-cycle tick every 2^(clk_div+1) clocks while not cleared.
module ppt_prescaler (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic [4:0] clk_div,
  output logic       tick
);

  logic [31:0] r_cnt;
  logic [31:0] w_term;

  // clk_div=31 yields an all-ones terminal value, i.e. the full 32-bit range.
  assign w_term = 32'hFFFF_FFFF >> (5'd31 - clk_div);
  assign tick   = !clr && (r_cnt == w_term);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_cnt <= '0;
    else if (clr || tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 32'd1;
  end

endmodule

// File: rtl/ppt_firing_ctrl.sv
// Pulsed-plasma-thruster firing sequencer: count pulses of width W every P ticks.
// Optional PPT_INTERLOCK_EN adds interlock_n, which aborts an active run to IDLE.
//
// state | meaning
// IDLE  | waiting for run_ppt, config transparent
// FIRE  | ppt_out high, counting width ticks
// GAP   | ppt_out low, counting to the period
// DONE  | all firings complete, hold until run_ppt drops
module ppt_firing_ctrl
  import ppt_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic [4:0]    clk_div,
  input  logic [FW-1:0] period,
  input  logic [FW-1:0] width,
  input  logic [FW-1:0] count,
  input  logic          run_ppt,
`ifdef PPT_INTERLOCK_EN
  input  logic          interlock_n,
`endif
  output logic          ppt_out,
  output logic          busy,
  output logic [FW-1:0] count_done,
  output logic          done
);

  ppt_state_e    r_state, w_next;
  logic [4:0]    r_clk_div;
  logic [FW-1:0] r_period, r_width, r_count, r_tick_cnt;
  logic [FW-1:0] w_p, w_w, w_w_in, w_tick_nxt, w_cd_inc;
  logic          w_tick, w_presc_clr, w_start;

  assign w_p        = eff_period(r_period);
  assign w_w        = eff_width(r_period, r_width);
  assign w_w_in     = eff_width(period, width);
  assign w_tick_nxt = r_tick_cnt + FW'(1);
  assign w_cd_inc   = (count_done == '1) ? count_done : count_done + FW'(1);
  assign w_start    = (r_state == ST_IDLE) && run_ppt;
  assign w_presc_clr = !((r_state == ST_FIRE) || (r_state == ST_GAP));

  ppt_prescaler u_presc (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (w_presc_clr),
    .clk_div (r_clk_div),
    .tick    (w_tick)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (run_ppt) begin
          if (count == '0)        w_next = ST_DONE;
          else if (w_w_in == '0)  w_next = ST_GAP;
          else                    w_next = ST_FIRE;
        end
      end
      ST_FIRE: if (w_tick && (w_tick_nxt == w_w)) w_next = ST_GAP;
      ST_GAP: begin
        if (w_tick && (w_tick_nxt == w_p)) begin
          if (w_cd_inc == r_count) w_next = ST_DONE;
          else if (w_w == '0)      w_next = ST_GAP;
          else                     w_next = ST_FIRE;
        end
      end
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
`ifdef PPT_INTERLOCK_EN
    if (!interlock_n && ((r_state == ST_FIRE) || (r_state == ST_GAP)))
      w_next = ST_IDLE;
`endif
    if (!run_ppt)
      w_next = ST_IDLE;
  end

  // Outputs decode the next state so they change together with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      ppt_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      ppt_out <= (w_next == ST_FIRE);
      busy    <= (w_next == ST_FIRE) || (w_next == ST_GAP);
      done    <= (w_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_div  <= '0;
      r_period   <= '0;
      r_width    <= '0;
      r_count    <= '0;
      r_tick_cnt <= '0;
      count_done <= '0;
    end else if (w_start) begin
      r_clk_div  <= clk_div;
      r_period   <= period;
      r_width    <= width;
      r_count    <= count;
      r_tick_cnt <= '0;
      count_done <= '0;
    end else if (w_tick && (w_next != ST_IDLE)) begin
      if ((r_state == ST_GAP) && (w_tick_nxt == w_p)) begin
        count_done <= w_cd_inc;
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= w_tick_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ppt_firing_ctrl.sv
// Self-checking bench for ppt_firing_ctrl; exercises interlock_n when PPT_INTERLOCK_EN is defined.
module tb_ppt_firing_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  clk_div;
  logic [15:0] period, width, count;
  logic        run_ppt;
`ifdef PPT_INTERLOCK_EN
  logic        interlock_n = 1'b1;
`endif
  logic        ppt_out, busy, done;
  logic [15:0] count_done;

  int ntotal = 0;
  int nbad   = 0;

  always #5 clk = ~clk;

  ppt_firing_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div    (clk_div),
    .period     (period),
    .width      (width),
    .count      (count),
    .run_ppt    (run_ppt),
`ifdef PPT_INTERLOCK_EN
    .interlock_n(interlock_n),
`endif
    .ppt_out    (ppt_out),
    .busy       (busy),
    .count_done (count_done),
    .done       (done)
  );

  // Expected outputs k cycles after the start edge, from the timing rules:
  // tick period T, pulse n high for cycles [n*P*T, n*P*T + W*T), done after C*P*T.
  function automatic void model(input longint k, input int cdiv, input int p_in, input int w_in,
                                input int c, output logic e_ppt, output logic e_busy,
                                output logic e_done, output logic [15:0] e_cd);
    longint pe, we, t, per, total;
    pe    = (p_in < 2) ? 2 : p_in;
    we    = (w_in < pe - 1) ? w_in : pe - 1;
    t     = longint'(1) << (cdiv + 1);
    per   = pe * t;
    total = longint'(c) * per;
    if (k < total) begin
      e_ppt  = (k % per) < (we * t);
      e_busy = 1'b1;
      e_done = 1'b0;
      e_cd   = 16'(k / per);
    end else begin
      e_ppt  = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b1;
      e_cd   = 16'(c);
    end
  endfunction

  // Called at a negedge with the DUT idle; runs ncyc cycles, then drops run_ppt.
  task automatic run_cfg(input int cdiv, input int p, input int w, input int c,
                         input int ncyc, input int chg_at, input string tag);
    logic        e_ppt, e_busy, e_done;
    logic [15:0] e_cd;
    e_cd    = '0;
    clk_div = 5'(cdiv);
    period  = 16'(p);
    width   = 16'(w);
    count   = 16'(c);
    run_ppt = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      model(longint'(k), cdiv, p, w, c, e_ppt, e_busy, e_done, e_cd);
      ntotal++;
      if ({ppt_out, busy, done, count_done} !== {e_ppt, e_busy, e_done, e_cd}) begin
        nbad++;
        $display("FAIL %s k=%0d ppt/busy/done got %b%b%b cnt %0d, want %b%b%b cnt %0d",
                 tag, k, ppt_out, busy, done, count_done, e_ppt, e_busy, e_done, e_cd);
      end
      if (k == chg_at) begin
        clk_div = 5'($urandom_range(0, 31));
        period  = 16'($urandom_range(0, 9));
        width   = 16'($urandom_range(0, 9));
        count   = 16'($urandom_range(0, 9));
      end
    end
    run_ppt = 1'b0;
    @(negedge clk);
    ntotal++;
    if ({ppt_out, busy, done, count_done} !== {3'b000, e_cd}) begin
      nbad++;
      $display("FAIL %s_stop ppt/busy/done got %b%b%b cnt %0d, want 000 cnt %0d",
               tag, ppt_out, busy, done, count_done, e_cd);
    end
  endtask

  task automatic test_reset();
    #2;
    ntotal++;
    if ({ppt_out, busy, done, count_done} !== 19'd0) begin
      nbad++;
      $display("FAIL reset ppt/busy/done got %b%b%b cnt %0d, want 000 cnt 0",
               ppt_out, busy, done, count_done);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_cfg(0, 4, 1, 3, 30, -1, "basic");
  endtask

  task automatic test_count_zero();
    run_cfg(0, 4, 1, 0, 6, -1, "count_zero");
  endtask

  task automatic test_clamps();
    run_cfg(0, 4, 10, 2, 20, -1, "width_clamp");
    run_cfg(1, 0, 5, 3, 28, -1, "period_zero");
    run_cfg(0, 3, 0, 2, 16, -1, "width_zero");
  endtask

  task automatic test_abort_restart();
    run_cfg(0, 4, 2, 5, 10, -1, "abort_2nd_pulse");
    run_cfg(0, 4, 2, 2, 20, -1, "restart");
  endtask

  task automatic test_config_change();
    run_cfg(1, 5, 2, 3, 65, 3, "cfg_change");
  endtask

  task automatic test_clkdiv_max();
    run_cfg(31, 3, 1, 2, 150, -1, "clkdiv_31");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_cfg(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
              int'($urandom_range(1, 240)),
              int'($urandom_range(0, 60)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_midrun();
    clk_div = 5'd0; period = 16'd4; width = 16'd2; count = 16'd3;
    run_ppt = 1'b1;
    for (int k = 0; k < 9; k++) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    ntotal++;
    if ({ppt_out, busy, done, count_done} !== 19'd0) begin
      nbad++;
      $display("FAIL reset_midrun ppt/busy/done got %b%b%b cnt %0d, want 000 cnt 0",
               ppt_out, busy, done, count_done);
    end
    run_ppt = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

`ifdef PPT_INTERLOCK_EN
  task automatic test_interlock();
    clk_div = 5'd0; period = 16'd4; width = 16'd2; count = 16'd3;
    run_ppt = 1'b1;
    for (int k = 0; k < 9; k++) @(negedge clk);
    interlock_n = 1'b0;
    @(negedge clk);
    ntotal++;
    if ({ppt_out, busy, done, count_done} !== {3'b000, 16'd1}) begin
      nbad++;
      $display("FAIL interlock ppt/busy/done got %b%b%b cnt %0d, want 000 cnt 1",
               ppt_out, busy, done, count_done);
    end
    run_ppt     = 1'b0;
    interlock_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    rstn    = 1'b0;
    clk_div = '0;
    period  = '0;
    width   = '0;
    count   = '0;
    run_ppt = 1'b0;
    test_reset();
    test_basic();
    test_count_zero();
    test_clamps();
    test_abort_restart();
    test_config_change();
    test_clkdiv_max();
    test_reset_midrun();
`ifdef PPT_INTERLOCK_EN
    test_interlock();
`endif
    test_random();
    test_basic();
    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule

// File: doc/ppt_firing_ctrl.md
PPT_FIRING_CTRL -- requirements
Module: ppt_firing_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rstn  in  1  asynchronous active-low reset.
REQ-002 SHALL have input clk_div  in  5  prescaler exponent; tick every 2^(clk_div+1) clk cycles.
REQ-003 SHALL have input period  in  16  firing period in ticks.
REQ-004 SHALL have input width  in  16  pulse width in ticks.
REQ-005 SHALL have input count  in  16  number of firings per run.
REQ-006 SHALL have input run_ppt  in  1  level-sensitive run enable.
REQ-007 SHALL have outputs ppt_out  out  1  registered firing pulse; busy  out  1  high outside IDLE/DONE.
REQ-008 SHALL have outputs count_done  out  16  completed firings; done  out  1  run complete.

Function
REQ-009 SHALL implement states IDLE, FIRE, GAP, DONE.
REQ-010 SHALL, in IDLE with run_ppt=1, latch clk_div/period/width/count, clear count_done, clear prescaler and tick counter, and enter FIRE the next cycle (or DONE if count=0, or GAP if effective width=0).
REQ-011 SHALL ignore changes to clk_div/period/width/count while not in IDLE (latched copies only).
REQ-012 SHALL use effective period P = max(period, 2).
REQ-013 SHALL use effective width W = min(width, P-1).
REQ-014 SHALL drive ppt_out=1 exactly in FIRE, registered, with no glitch on state entry.
REQ-015 SHALL generate tick from a 32-bit prescaler that asserts on terminal value 2^(clk_div+1)-1 and then wraps to 0; clk_div=31 uses the full 32-bit range.
REQ-016 SHALL count ticks from pulse start; FIRE->GAP on the tick reaching W.
REQ-017 SHALL, on the tick reaching P, increment count_done (16-bit, saturating at 0xFFFF).
REQ-018 SHALL then restart the tick counter and enter FIRE (or GAP if W=0), or enter DONE if the incremented count_done equals latched count.
REQ-019 SHALL hold done=1 in DONE, and SHALL NOT restart while run_ppt stays 1.
REQ-020 SHALL, when run_ppt=0 in any state, enter IDLE the next cycle, force ppt_out=0, clear done, and retain count_done.
REQ-021 SHALL keep busy=1 in FIRE and GAP only.

Reset
REQ-022 SHALL, on rstn=0, asynchronously set state=IDLE, ppt_out=0, busy=0, done=0, count_done=0, and clear prescaler, tick counter and latched config.
REQ-023 SHALL, on reset asserted mid-run, drop ppt_out within the reset assertion, not on the next clock edge.

Configuration
REQ-024 SHALL, with PPT_INTERLOCK_EN defined, add input interlock_n  in  1; interlock_n=0 in FIRE or GAP forces IDLE next cycle, drives ppt_out=0, and does not set done.
REQ-025 SHALL, without PPT_INTERLOCK_EN, omit the interlock_n port and all interlock logic.

Structure
REQ-026 SHALL take the state encoding, the 16-bit field width and the minimum period constant (2) from shared package ppt_pkg.
REQ-027 SHALL instantiate sub-module ppt_prescaler (clk, rstn, clr, clk_div -> tick).

Verification
REQ-028 clk_div=0, period=4, width=1, count=3, run_ppt=1 -> ppt_out high for 2 clk every 8 clk, 3 pulses, then done=1 and count_done=3.
REQ-029 count=0, run_ppt=1 -> DONE next cycle, done=1, ppt_out never high, count_done=0.
REQ-030 width=10, period=4 -> each pulse lasts 3 ticks then 1 tick low; period=0 behaves as period=2.
REQ-031 run_ppt dropped during the 2nd pulse -> ppt_out=0 next cycle, count_done=1, done=0; reassert -> count_done cleared to 0 and firing restarts.
REQ-032 period changed mid-run -> timing unchanged until the next start from IDLE.
REQ-033 with PPT_INTERLOCK_EN defined, interlock_n=0 during FIRE -> IDLE next cycle, ppt_out=0, done=0.
